// File: rtl/mult_arbiter.sv
// Round-robin sharing of one signed fixed-point multiply/dequantize unit among NUM_REQ operand FIFO pairs.
// Optional MULT_ARB_PRIO0_EN: requester 0 gets fixed top priority; 1..NUM_REQ-1 round-robin among themselves.
module mult_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 32,
    parameter int BITS      = 10
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             x_empty,
    input  logic [NUM_REQ-1:0]             y_empty,
    output logic [NUM_REQ-1:0]             x_rd_en,
    output logic [NUM_REQ-1:0]             y_rd_en,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   x_din,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   y_din,
    input  logic [NUM_REQ-1:0]             out_full,
    output logic [NUM_REQ-1:0]             out_wr_en,
    output logic [DATA_SIZE-1:0]           dout,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int PW = 2 * DATA_SIZE;

    typedef enum logic {ARB, WRITE} state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         last_grant_q, last_grant_d;
    logic [GW-1:0]         grant_id_q, grant_id_d;
    logic signed [PW-1:0]  prod_q, prod_d;

    logic [NUM_REQ-1:0]    elig;
    logic [DATA_SIZE-1:0]  x_arr [NUM_REQ];
    logic [DATA_SIZE-1:0]  y_arr [NUM_REQ];
    logic [DATA_SIZE-1:0]  xs, ys;
    logic                  found;
    logic [GW-1:0]         g;
    int                    cand;

    assign elig = ~x_empty & ~y_empty;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            x_arr[i] = x_din[i*DATA_SIZE +: DATA_SIZE];
            y_arr[i] = y_din[i*DATA_SIZE +: DATA_SIZE];
        end
    end

    // Winner search: first eligible requester after last_grant in cyclic order.
    always_comb begin
        found = 1'b0;
        g     = '0;
        cand  = 0;
`ifdef MULT_ARB_PRIO0_EN
        if (elig[0]) begin
            found = 1'b1;
        end else begin
            for (int k = 1; k < NUM_REQ; k++) begin
                cand = (int'(last_grant_q) + NUM_REQ - 2 + k) % (NUM_REQ - 1) + 1;
                if (!found && elig[GW'(cand)]) begin
                    found = 1'b1;
                    g     = GW'(cand);
                end
            end
        end
`else
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_grant_q) + k) % NUM_REQ;
            if (!found && elig[GW'(cand)]) begin
                found = 1'b1;
                g     = GW'(cand);
            end
        end
`endif
    end

    assign xs = x_arr[g];
    assign ys = y_arr[g];

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        prod_d       = prod_q;
        x_rd_en      = '0;
        y_rd_en      = '0;
        out_wr_en    = '0;
        if (!reset) begin
            case (state_q)
                ARB: begin
                    if (found) begin
                        x_rd_en[g] = 1'b1;
                        y_rd_en[g] = 1'b1;
                        prod_d     = {{DATA_SIZE{xs[DATA_SIZE-1]}}, xs} *
                                     {{DATA_SIZE{ys[DATA_SIZE-1]}}, ys};
                        grant_id_d = g;
`ifdef MULT_ARB_PRIO0_EN
                        if (g != '0) last_grant_d = g;
`else
                        last_grant_d = g;
`endif
                        state_d    = WRITE;
                    end
                end
                WRITE: begin
                    // Head-of-line blocking: hold the product until its own result FIFO has room.
                    if (!out_full[grant_id_q]) begin
                        out_wr_en[grant_id_q] = 1'b1;
                        state_d               = ARB;
                    end
                end
                default: state_d = ARB;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ARB;
            last_grant_q <= GW'(NUM_REQ - 1);
            grant_id_q   <= '0;
            prod_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            prod_q       <= prod_d;
        end
    end

    // prod only changes on a grant, so the shifted value also holds between writes.
    assign dout     = DATA_SIZE'(prod_q >>> BITS);
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: directed vector table, hand sequences, randomized run against a reference model.
module tb_mult_arbiter;
    localparam int N  = 4;
    localparam int DS = 32;
    localparam int B  = 10;

    logic              clock = 1'b0;
    logic              reset;
    logic [N-1:0]      x_empty, y_empty, x_rd_en, y_rd_en, out_full, out_wr_en;
    logic [N*DS-1:0]   x_din, y_din;
    logic [DS-1:0]     dout;
    logic [1:0]        grant_id;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mult_arbiter #(.NUM_REQ(N), .DATA_SIZE(DS), .BITS(B)) dut (
        .clock(clock), .reset(reset),
        .x_empty(x_empty), .y_empty(y_empty),
        .x_rd_en(x_rd_en), .y_rd_en(y_rd_en),
        .x_din(x_din), .y_din(y_din),
        .out_full(out_full), .out_wr_en(out_wr_en),
        .dout(dout), .grant_id(grant_id)
    );

    // Reference model: at most one pending result, a round-robin pointer, and the last winner.
    bit            m_busy;
    int            m_id, m_last, m_gid, m_g;
    logic [DS-1:0] m_val, m_nval;
    logic [N-1:0]  e_rd, e_wr;
    logic [DS-1:0] e_dout;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic longint opnd(input logic [N*DS-1:0] bus, input int i);
        logic [N*DS-1:0]    s;
        logic signed [DS-1:0] v;
        s = bus >> (i * DS);
        v = s[DS-1:0];
        return longint'(v);
    endfunction

    function automatic logic [DS-1:0] fx(input longint a, input longint b);
        longint p;
        p = (a * b) >>> B;
        return p[DS-1:0];
    endfunction

    function automatic bit elig(input int c);
        logic [N-1:0] e;
        e = (~x_empty & ~y_empty) >> c;
        return e[0];
    endfunction

    function automatic bit full_at(input int c);
        logic [N-1:0] f;
        f = out_full >> c;
        return f[0];
    endfunction

    task automatic model_reset();
        m_busy = 0; m_last = N - 1; m_gid = 0; m_id = 0; m_val = '0;
    endtask

    task automatic predict();
        int c;
        e_rd = '0; e_wr = '0; e_dout = '0; m_g = -1;
        if (reset) return;
        if (m_busy) begin
            if (!full_at(m_id)) begin
                e_wr   = N'(1) << m_id;
                e_dout = m_val;
            end
        end else begin
`ifdef MULT_ARB_PRIO0_EN
            if (elig(0)) m_g = 0;
            else for (int k = 1; k < N; k++) begin
                c = 1 + (m_last - 1 + k) % (N - 1);
                if (m_g < 0 && elig(c)) m_g = c;
            end
`else
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (m_g < 0 && elig(c)) m_g = c;
            end
`endif
            if (m_g >= 0) begin
                e_rd   = N'(1) << m_g;
                m_nval = fx(opnd(x_din, m_g), opnd(y_din, m_g));
            end
        end
    endtask

    task automatic advance();
        if (m_busy) begin
            if (e_wr != '0) m_busy = 0;
        end else if (m_g >= 0) begin
            m_busy = 1; m_id = m_g; m_val = m_nval; m_gid = m_g;
`ifdef MULT_ARB_PRIO0_EN
            if (m_g != 0) m_last = m_g;
`else
            m_last = m_g;
`endif
        end
    endtask

    // Called just after a negedge with inputs driven; returns just after the next negedge.
    task automatic step();
        #1;
        predict();
        chk("x_rd_en", 64'(x_rd_en), 64'(e_rd));
        chk("y_rd_en", 64'(y_rd_en), 64'(e_rd));
        chk("out_wr_en", 64'(out_wr_en), 64'(e_wr));
        chk("grant_id", 64'(grant_id), 64'(reset ? 0 : m_gid));
        if (reset || e_wr != '0) chk("dout", 64'(dout), 64'(e_dout));
        @(posedge clock);
        if (reset) model_reset(); else advance();
        @(negedge clock);
    endtask

    task automatic drive(input logic [N-1:0] xe, input logic [N-1:0] ye, input logic [N-1:0] of,
                         input logic [DS-1:0] xv, input logic [DS-1:0] yv);
        x_empty = xe; y_empty = ye; out_full = of;
        x_din = {N{xv}}; y_din = {N{yv}};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0]  xe, ye, of;
        logic [DS-1:0] xv, yv;
        logic [N-1:0]  rd, wr;
        bit            dchk;
        logic [DS-1:0] d;
    } vec_t;

    vec_t          tbl [13];
    logic [N-1:0]  exp_g;

    initial begin
        tbl[0]  = '{4'b1110, 4'b1110, 4'b0000, 32'd3072, 32'd2048, 4'b0001, 4'b0000, 1'b0, 32'd0};
        tbl[1]  = '{4'b1111, 4'b1111, 4'b0000, 32'd0, 32'd0, 4'b0000, 4'b0001, 1'b1, 32'd6144};
        tbl[2]  = '{4'b1011, 4'b1011, 4'b0000, -32'sd1536, 32'd2048, 4'b0100, 4'b0000, 1'b0, 32'd0};
        tbl[3]  = '{4'b1111, 4'b1111, 4'b0000, 32'd0, 32'd0, 4'b0000, 4'b0100, 1'b1, -32'sd3072};
        tbl[4]  = '{4'b1101, 4'b1101, 4'b0000, 32'd5120, 32'd1024, 4'b0010, 4'b0000, 1'b0, 32'd0};
        for (int i = 5; i < 10; i++)
            tbl[i] = '{4'b1001, 4'b1001, 4'b0010, 32'd5120, 32'd1024, 4'b0000, 4'b0000, 1'b1, 32'd5120};
        tbl[10] = '{4'b1001, 4'b1001, 4'b0000, 32'd5120, 32'd1024, 4'b0000, 4'b0010, 1'b1, 32'd5120};
        tbl[11] = '{4'b1001, 4'b1001, 4'b0000, 32'd5120, 32'd1024, 4'b0100, 4'b0000, 1'b0, 32'd0};
        tbl[12] = '{4'b1111, 4'b1111, 4'b0000, 32'd5120, 32'd1024, 4'b0000, 4'b0100, 1'b1, 32'd5120};

        reset = 1'b1;
        drive('1, '1, '0, '0, '0);
        model_reset();
        repeat (2) @(negedge clock);
        #1;
        chk("reset_rd", 64'(x_rd_en | y_rd_en), 64'(0));
        chk("reset_wr", 64'(out_wr_en), 64'(0));
        chk("reset_dout", 64'(dout), 64'(0));
        chk("reset_gid", 64'(grant_id), 64'(0));
        @(negedge clock);
        reset = 1'b0;

        // Directed vectors: basic product, negative operands, result-FIFO-full stall.
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].xe, tbl[i].ye, tbl[i].of, tbl[i].xv, tbl[i].yv);
            #1;
            chk($sformatf("vec%0d_rd", i), 64'(x_rd_en), 64'(tbl[i].rd));
            chk($sformatf("vec%0d_wr", i), 64'(out_wr_en), 64'(tbl[i].wr));
            if (tbl[i].dchk) chk($sformatf("vec%0d_dout", i), 64'(dout), 64'(tbl[i].d));
            step();
        end

        // Reset while a product is pending: no write, requester 0 first afterwards.
        drive(4'b1110, 4'b1110, 4'b0000, 32'd7168, 32'd1024);
        step();
        reset = 1'b1;
        #1;
        chk("midrst_wr", 64'(out_wr_en), 64'(0));
        chk("midrst_rd", 64'(x_rd_en | y_rd_en), 64'(0));
        step();
        reset = 1'b0;
        drive(4'b1100, 4'b1100, 4'b0000, 32'd1024, 32'd1024);
        #1;
        chk("postrst_first", 64'(x_rd_en), 64'(4'b0001));
        step();
        step();

        // All requesters continuously eligible.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(4'b0000, 4'b0000, 4'b0000, $urandom, $urandom);
`ifdef MULT_ARB_PRIO0_EN
            exp_g = 4'b0001;
`else
            exp_g = N'(1) << (k % N);
`endif
            #1;
            chk($sformatf("rr_grant%0d", k), 64'(x_rd_en), 64'(exp_g));
            step();
            #1;
            chk($sformatf("rr_write%0d", k), 64'(out_wr_en), 64'(exp_g));
            chk($sformatf("rr_nord%0d", k), 64'(x_rd_en | y_rd_en), 64'(0));
            step();
        end

`ifdef MULT_ARB_PRIO0_EN
        // Requester 0 priority over requester 3, yielding only while empty.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            if (k == 3) drive(4'b0111, 4'b0111, 4'b0000, 32'd2048, 32'd2048);
            else        drive(4'b0110, 4'b0110, 4'b0000, 32'd2048, 32'd2048);
            exp_g = (k == 3) ? 4'b1000 : 4'b0001;
            #1;
            chk($sformatf("prio_grant%0d", k), 64'(x_rd_en), 64'(exp_g));
            step();
            step();
        end
`endif

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            x_empty  = N'($urandom & $urandom);
            y_empty  = N'($urandom & $urandom);
            out_full = N'($urandom & $urandom & $urandom);
            for (int i = 0; i < N; i++) begin
                x_din[i*DS +: DS] = ($urandom % 2 == 1) ? $urandom : DS'($urandom_range(0, 65535) - 32768);
                y_din[i*DS +: DS] = ($urandom % 2 == 1) ? $urandom : DS'($urandom_range(0, 65535) - 32768);
            end
            reset = ($urandom % 250 == 0);
            step();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
